// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: issues one PC redirect and matching flushes per taken branch.
// Optional saturating redirect statistics are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl #(
    parameter int PC_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_taken,
    input  logic             exe_taken,
    input  logic [PC_W-1:0]  id_bra_pc,
    input  logic [PC_W-1:0]  exe_bra_pc,
    input  logic             stall_in,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_target,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] exe_cnt
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state;
    logic [PC_W-1:0] pend_pc;
    logic            pend_exe;
    logic            busy_q;
    logic            any_taken;
    logic [PC_W-1:0] sel_pc;

    // The EXE branch is older, so it wins and the ID branch is on the wrong path.
    assign any_taken = id_taken | exe_taken;
    assign sel_pc    = exe_taken ? exe_bra_pc : id_bra_pc;
    assign busy      = busy_q;

    always_comb begin
        pc_load      = 1'b0;
        pc_target    = '0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (!rst && !stall_in) begin
            if (state == HOLD) begin
                pc_load      = 1'b1;
                pc_target    = pend_pc;
                if_id_flush  = 1'b1;
                id_exe_flush = pend_exe;
            end else if (any_taken) begin
                pc_load      = 1'b1;
                pc_target    = sel_pc;
                if_id_flush  = 1'b1;
                id_exe_flush = exe_taken;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pend_pc  <= '0;
            pend_exe <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (any_taken && stall_in) begin
                        state    <= HOLD;
                        pend_pc  <= sel_pc;
                        pend_exe <= exe_taken;
                        busy_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] exe_cnt_q;

    // id_exe_flush is raised exactly when the issued redirect came from EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_q <= '0;
            exe_cnt_q   <= '0;
        end else if (pc_load) begin
            taken_cnt_q <= sat_inc(taken_cnt_q);
            if (id_exe_flush)
                exe_cnt_q <= sat_inc(exe_cnt_q);
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign exe_cnt   = exe_cnt_q;
`else
    assign taken_cnt = '0;
    assign exe_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; stats expectations follow BRANCH_STATS_EN.
module tb_branch_redirect_ctrl;

    localparam int PC_W  = 6;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             id_taken;
    logic             exe_taken;
    logic [PC_W-1:0]  id_bra_pc;
    logic [PC_W-1:0]  exe_bra_pc;
    logic             stall_in;
    logic             pc_load;
    logic [PC_W-1:0]  pc_target;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic             busy;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] exe_cnt;

    int checks   = 0;
    int failures = 0;

    branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_taken    (id_taken),
        .exe_taken   (exe_taken),
        .id_bra_pc   (id_bra_pc),
        .exe_bra_pc  (exe_bra_pc),
        .stall_in    (stall_in),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .if_id_flush (if_id_flush),
        .id_exe_flush(id_exe_flush),
        .busy        (busy),
        .taken_cnt   (taken_cnt),
        .exe_cnt     (exe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic it, input logic [PC_W-1:0] ipc,
                         input logic et, input logic [PC_W-1:0] epc, input logic st);
        @(negedge clk);
        id_taken   = it;
        id_bra_pc  = ipc;
        exe_taken  = et;
        exe_bra_pc = epc;
        stall_in   = st;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 6'h15, 1'b0, 6'h00, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (pc_load !== 1'b0 || pc_target !== 6'h00 || if_id_flush !== 1'b0 ||
            id_exe_flush !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got load=%b tgt=%h iff=%b ief=%b busy=%b expected all 0",
                     pc_load, pc_target, if_id_flush, id_exe_flush, busy);
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
            checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle got load=%b busy=%b expected 0 0", pc_load, busy);
            end
        end
    endtask

    task automatic test_id_redirect();
        drive(1'b1, 6'h15, 1'b0, 6'h00, 1'b0);
        checks++;
        if (pc_load !== 1'b1 || pc_target !== 6'h15 || if_id_flush !== 1'b1 ||
            id_exe_flush !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL id_redirect got load=%b tgt=%h iff=%b ief=%b busy=%b expected 1 15 1 0 0",
                     pc_load, pc_target, if_id_flush, id_exe_flush, busy);
        end
        drive(1'b0, 6'h15, 1'b0, 6'h00, 1'b0);
        checks++;
        if (pc_load !== 1'b0 || pc_target !== 6'h00) begin
            failures++;
            $display("FAIL id_after got load=%b tgt=%h expected 0 00", pc_load, pc_target);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 6'h03, 1'b1, 6'h2A, 1'b0);
        checks++;
        if (pc_load !== 1'b1 || pc_target !== 6'h2A || if_id_flush !== 1'b1 ||
            id_exe_flush !== 1'b1) begin
            failures++;
            $display("FAIL priority got load=%b tgt=%h iff=%b ief=%b expected 1 2a 1 1",
                     pc_load, pc_target, if_id_flush, id_exe_flush);
        end
        drive(1'b0, 6'h03, 1'b0, 6'h2A, 1'b0);
        checks++;
        if (pc_load !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL priority_single got load=%b busy=%b expected 0 0", pc_load, busy);
        end
    endtask

    task automatic test_stalled_redirect();
        drive(1'b0, 6'h00, 1'b1, 6'h3F, 1'b1);
        checks++;
        if (pc_load !== 1'b0 || if_id_flush !== 1'b0 || id_exe_flush !== 1'b0) begin
            failures++;
            $display("FAIL stall_capture got load=%b iff=%b ief=%b expected 0 0 0",
                     pc_load, if_id_flush, id_exe_flush);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h01, 1'b0, 6'h00, 1'b1);
            checks++;
            if (busy !== 1'b1 || pc_load !== 1'b0 || pc_target !== 6'h00) begin
                failures++;
                $display("FAIL stall_hold[%0d] got busy=%b load=%b tgt=%h expected 1 0 00",
                         i, busy, pc_load, pc_target);
            end
        end
        drive(1'b1, 6'h01, 1'b0, 6'h00, 1'b0);
        checks++;
        if (pc_load !== 1'b1 || pc_target !== 6'h3F || if_id_flush !== 1'b1 ||
            id_exe_flush !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got load=%b tgt=%h iff=%b ief=%b busy=%b expected 1 3f 1 1 1",
                     pc_load, pc_target, if_id_flush, id_exe_flush, busy);
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        checks++;
        if (busy !== 1'b0 || pc_load !== 1'b0) begin
            failures++;
            $display("FAIL stall_back_run got busy=%b load=%b expected 0 0", busy, pc_load);
        end
    endtask

    task automatic test_reset_hold();
        drive(1'b1, 6'h10, 1'b0, 6'h00, 1'b1);
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rsthold_enter got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pc_load !== 1'b0) begin
            failures++;
            $display("FAIL rsthold_async got busy=%b load=%b expected 0 0", busy, pc_load);
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0 || pc_target !== 6'h00) begin
                failures++;
                $display("FAIL rsthold_release[%0d] got load=%b busy=%b tgt=%h expected 0 0 00",
                         i, pc_load, busy, pc_target);
            end
            drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] exp_tgt [3];
        logic            exp_ief [3];
        exp_tgt[0] = 6'h05; exp_ief[0] = 1'b0;
        exp_tgt[1] = 6'h22; exp_ief[1] = 1'b1;
        exp_tgt[2] = 6'h07; exp_ief[2] = 1'b0;
        drive(1'b1, 6'h05, 1'b0, 6'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc_load !== 1'b1 || pc_target !== exp_tgt[i] || id_exe_flush !== exp_ief[i] ||
                if_id_flush !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d] got load=%b tgt=%h ief=%b iff=%b expected 1 %h %b 1",
                         i, pc_load, pc_target, id_exe_flush, if_id_flush, exp_tgt[i], exp_ief[i]);
            end
            if (i == 0) drive(1'b1, 6'h09, 1'b1, 6'h22, 1'b0);
            if (i == 1) drive(1'b1, 6'h07, 1'b0, 6'h33, 1'b0);
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    endtask

    task automatic test_stats();
        int t_m;
        int e_m;
        int max_c;
        max_c = (1 << CNT_W) - 1;
        t_m = 0;
        e_m = 0;
        rst = 1'b1;
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        rst = 1'b0;
        drive(1'b1, 6'h11, 1'b0, 6'h00, 1'b0);
`ifdef BRANCH_STATS_EN
        if (t_m < max_c) t_m++;
`endif
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 6'h00, 1'b1, 6'(k + 8), 1'b0);
            checks++;
            if (taken_cnt !== CNT_W'(t_m) || exe_cnt !== CNT_W'(e_m)) begin
                failures++;
                $display("FAIL stats[%0d] got taken=%0d exe=%0d expected %0d %0d",
                         k, taken_cnt, exe_cnt, t_m, e_m);
            end
`ifdef BRANCH_STATS_EN
            if (t_m < max_c) t_m++;
            if (e_m < max_c) e_m++;
`endif
        end
        drive(1'b0, 6'h00, 1'b1, 6'h3A, 1'b1);
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
`ifdef BRANCH_STATS_EN
        if (t_m < max_c) t_m++;
        if (e_m < max_c) e_m++;
`endif
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        checks++;
        if (taken_cnt !== CNT_W'(t_m) || exe_cnt !== CNT_W'(e_m)) begin
            failures++;
            $display("FAIL stats_final got taken=%0d exe=%0d expected %0d %0d",
                     taken_cnt, exe_cnt, t_m, e_m);
        end
    endtask

    initial begin
        rst        = 1'b1;
        id_taken   = 1'b0;
        exe_taken  = 1'b0;
        id_bra_pc  = '0;
        exe_bra_pc = '0;
        stall_in   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_id_redirect();
        test_priority();
        test_stalled_redirect();
        test_reset_hold();
        test_back_to_back();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for the branch datapath. It takes the taken-branch decisions resolved in ID (equality branches) and EXE (greater/less-or-equal branches) and issues one PC redirect per decision. It flushes the matching pipeline registers and holds a redirect pending while the pipeline is stalled. It sits between the branch logic, the PC register and the IF/ID and ID/EXE pipeline registers.

## Interface
Parameters:
- PC_W, 6, width of PC and branch targets
- CNT_W, 8, width of statistics counters (used only with BRANCH_STATS_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-high
- id_taken  in  1  equality branch in ID resolved taken
- exe_taken  in  1  compare branch in EXE resolved taken
- id_bra_pc  in  PC_W  target for ID-resolved branch
- exe_bra_pc  in  PC_W  target for EXE-resolved branch
- stall_in  in  1  pipeline stall; PC and pipeline registers frozen this cycle
- pc_load  out  1  load PC with pc_target at next edge
- pc_target  out  PC_W  redirect target
- if_id_flush  out  1  clear IF/ID at next edge
- id_exe_flush  out  1  clear ID/EXE at next edge
- busy  out  1  redirect pending (HOLD state)
- taken_cnt  out  CNT_W  taken redirects issued (BRANCH_STATS_EN only)
- exe_cnt  out  CNT_W  redirects sourced from EXE (BRANCH_STATS_EN only)

## Operation
- FSM states: RUN, HOLD. Reset state is RUN.
- Source select: exe_taken has priority over id_taken, because the EXE instruction is older. When both are asserted, the ID branch is on the wrong path and is discarded.
- RUN, no taken input: all outputs are 0.
- RUN, taken input and stall_in = 0:
  - Assert pc_load with pc_target = selected target, combinationally in the same cycle.
  - Always assert if_id_flush.
  - Assert id_exe_flush only if the EXE source was selected.
  - Stay in RUN.
- RUN, taken input and stall_in = 1:
  - Capture the target and source into pend_pc / pend_exe.
  - Drive no outputs; go to HOLD.
- HOLD:
  - busy = 1; taken inputs are ignored.
  - While stall_in = 1: outputs are 0 and pend_* is held.
  - First cycle with stall_in = 0: drive pc_load = 1, pc_target = pend_pc, if_id_flush = 1, id_exe_flush = pend_exe; return to RUN.
- pc_target is 0 whenever pc_load = 0.
- Exactly one redirect is issued per accepted decision. No redirect is ever issued while stall_in = 1.

## Timing
- Reset values:
  - pc_load, pc_target, if_id_flush, id_exe_flush, busy all 0.
  - State RUN; pend_pc = 0, pend_exe = 0.
  - Counters 0.
- Latency from an unstalled taken input to pc_load is 0 cycles (combinational). The PC changes at the following rising edge.
- Latency from HOLD to redirect is 0 cycles after stall_in deasserts.
- pend_pc / pend_exe update only on the RUN→HOLD transition.
- rst asserted mid-HOLD discards the pending redirect immediately (asynchronous). No pc_load is issued after rst deasserts.
- Back-to-back taken inputs in consecutive unstalled RUN cycles each produce a redirect. Squashing wrong-path instructions is the job of the flush outputs.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_cnt increments on every cycle where pc_load = 1.
  - exe_cnt increments when pc_load = 1 and the source is EXE.
  - Both counters saturate at 2^CNT_W-1 and do not wrap. Both reset to 0.
- BRANCH_STATS_EN undefined:
  - Counter registers are not built.
  - taken_cnt and exe_cnt are tied to 0.
  - Redirect behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately and state RUN. After release with no inputs, pc_load stays 0.
- ID redirect: id_taken = 1, id_bra_pc = 6'h15, stall_in = 0 → same cycle pc_load = 1, pc_target = 6'h15, if_id_flush = 1, id_exe_flush = 0.
- Priority: id_taken = 1 (id_bra_pc = 6'h03) and exe_taken = 1 (exe_bra_pc = 6'h2A) together → pc_target = 6'h2A, both flushes = 1, one redirect only.
- Stalled redirect: exe_taken = 1, exe_bra_pc = 6'h3F with stall_in = 1 for 3 cycles, then input changed to id_taken = 1, id_bra_pc = 6'h01 → busy = 1 for 3 cycles with no pc_load. In the cycle stall_in drops: pc_load = 1, pc_target = 6'h3F, id_exe_flush = 1, then RUN.
- Reset mid-HOLD: enter HOLD with target 6'h10, pulse rst, drop stall_in → no pc_load and busy = 0.
- Stats (BRANCH_STATS_EN, CNT_W = 2): 5 EXE redirects → taken_cnt = 3 and exe_cnt = 3 (saturated). Without the macro, both read 0.
